// File: rtl/step2_pkg.sv
// step2_pkg: shared sizes, datapath types and output narrowing for the PBVI backup stage 2.
// Narrowing saturates when STEP2_SATURATE_EN is defined, otherwise wraps.
package step2_pkg;

    localparam int NUM_ACTIONS = 3;
    localparam int NUM_OBS     = 2;
    localparam int NUM_ALPHA   = 16;
    localparam int NUM_BELIEF  = 16;
    localparam int NUM_STATES  = 2;
    localparam int W           = 16;
    localparam int KW          = $clog2(NUM_ALPHA);

    typedef logic signed [W-1:0] word_t;
    typedef logic        [W-1:0] belief_t;
    typedef logic signed [33:0]  dot_t;
    // reward plus NUM_OBS selected alphas needs two guard bits
    typedef logic signed [W+1:0] sum_t;

`ifdef STEP2_SATURATE_EN
    localparam sum_t SUM_MAX = sum_t'(2 ** (W - 1) - 1);
    localparam sum_t SUM_MIN = sum_t'(-(2 ** (W - 1)));
`endif

    function automatic word_t narrow(input sum_t x);
`ifdef STEP2_SATURATE_EN
        return (x > SUM_MAX) ? word_t'(SUM_MAX) : (x < SUM_MIN) ? word_t'(SUM_MIN) : word_t'(x);
`else
        return word_t'(x);
`endif
    endfunction

endpackage

// File: rtl/step2_argmax.sv
// step2_argmax: one (a,o,b) lane; picks the alpha vector with the largest dot product
// against the belief, lowest index winning ties.
module step2_argmax
    import step2_pkg::*;
(
    input  word_t   alpha_i  [NUM_ALPHA-1:0][NUM_STATES-1:0],
    input  belief_t belief_i [NUM_STATES-1:0],
    output word_t   sel_o    [NUM_STATES-1:0]
);

    dot_t          dot [NUM_ALPHA-1:0];
    dot_t          best;
    logic [KW-1:0] idx;

    always_comb begin
        dot_t acc;
        for (int k = 0; k < NUM_ALPHA; k++) begin
            acc = '0;
            for (int s = 0; s < NUM_STATES; s++)
                acc = acc + dot_t'(alpha_i[k][s]) * dot_t'($signed({1'b0, belief_i[s]}));
            dot[k] = acc;
        end
    end

    // strict greater-than keeps the earliest candidate on equal dot products
    always_comb begin
        best = dot[0];
        idx  = '0;
        for (int k = 1; k < NUM_ALPHA; k++) begin
            if (dot[k] > best) begin
                best = dot[k];
                idx  = KW'(k);
            end
        end
    end

    assign sel_o = alpha_i[idx];

endmodule

// File: rtl/step2.sv
// step2: PBVI backup stage 2; gamma_a_b = reward + sum over o of the best alpha per (a,o,b).
// Single-cycle combinational datapath with registered outputs; STEP2_SATURATE_EN selects saturation.
module step2
    import step2_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  word_t   gamma_intermediate_action_observation_alpha [NUM_ACTIONS-1:0][NUM_OBS-1:0][NUM_ALPHA-1:0][NUM_STATES-1:0],
    input  word_t   gamma_reward_action [NUM_ACTIONS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0],
    input  belief_t point_belief [NUM_BELIEF-1:0][NUM_STATES-1:0],
    output logic    en_step3,
    output word_t   gamma_action_bilief [NUM_ACTIONS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0]
);

    word_t sel   [NUM_ACTIONS-1:0][NUM_OBS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0];
    word_t out_d [NUM_ACTIONS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0];
    word_t out_q [NUM_ACTIONS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0];
    logic  en_q;

    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_act
        for (genvar o = 0; o < NUM_OBS; o++) begin : g_obs
            for (genvar b = 0; b < NUM_BELIEF; b++) begin : g_bel
                step2_argmax u_lane (
                    .alpha_i  (gamma_intermediate_action_observation_alpha[a][o]),
                    .belief_i (point_belief[b]),
                    .sel_o    (sel[a][o][b])
                );
            end
        end
    end

    always_comb begin
        sum_t acc;
        for (int a = 0; a < NUM_ACTIONS; a++) begin
            for (int b = 0; b < NUM_BELIEF; b++) begin
                for (int s = 0; s < NUM_STATES; s++) begin
                    acc = sum_t'(gamma_reward_action[a][b][s]);
                    for (int o = 0; o < NUM_OBS; o++)
                        acc = acc + sum_t'(sel[a][o][b][s]);
                    out_d[a][b][s] = narrow(acc);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '{default: '0};
            en_q  <= 1'b0;
        end else begin
            en_q <= en;
            if (en)
                out_q <= out_d;
        end
    end

    assign en_step3            = en_q;
    assign gamma_action_bilief = out_q;

endmodule

// File: tb/tb_step2.sv
// tb_step2: scoreboard bench for step2; a behavioural model queues expected elements at each
// en edge, constant tables cover the worked examples, tie-break and overflow corners.
module tb_step2;
    import step2_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    en = 1'b0;
    word_t   alpha  [NUM_ACTIONS-1:0][NUM_OBS-1:0][NUM_ALPHA-1:0][NUM_STATES-1:0];
    word_t   reward [NUM_ACTIONS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0];
    belief_t belief [NUM_BELIEF-1:0][NUM_STATES-1:0];
    logic    en_step3;
    word_t   out    [NUM_ACTIONS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0];
    word_t   last_exp [NUM_ACTIONS-1:0][NUM_BELIEF-1:0][NUM_STATES-1:0];

    typedef struct { int a; int b; int s; logic [15:0] v; } sb_t;
    sb_t sbq[$];

    typedef struct { int a; int b; logic [15:0] e0; logic [15:0] e1; } ex_t;
    typedef struct {
        logic [15:0] base0, base1, k7_0, k7_1, k12_0, k12_1, bel0, e0, e1;
    } tie_t;

    int tests = 0;
    int fails = 0;

    step2 dut (
        .clk                                         (clk),
        .rst_n                                       (rst_n),
        .en                                          (en),
        .gamma_intermediate_action_observation_alpha (alpha),
        .gamma_reward_action                         (reward),
        .point_belief                                (belief),
        .en_step3                                    (en_step3),
        .gamma_action_bilief                         (out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: act=%h req=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model(input int a, input int b, input int s);
        int     sum;
        int     bk;
        longint d, bd;
        sum = int'(reward[a][b][s]);
        for (int o = 0; o < NUM_OBS; o++) begin
            bk = 0;
            bd = 0;
            for (int k = 0; k < NUM_ALPHA; k++) begin
                d = 0;
                for (int t = 0; t < NUM_STATES; t++)
                    d += longint'(alpha[a][o][k][t]) * longint'({16'h0, belief[b][t]});
                if (k == 0 || d > bd) begin
                    bd = d;
                    bk = k;
                end
            end
            sum += int'(alpha[a][o][bk][s]);
        end
`ifdef STEP2_SATURATE_EN
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
`endif
        return 16'(sum);
    endfunction

    task automatic push_expected();
        logic [15:0] e;
        for (int a = 0; a < NUM_ACTIONS; a++)
            for (int b = 0; b < NUM_BELIEF; b++)
                for (int s = 0; s < NUM_STATES; s++) begin
                    e = model(a, b, s);
                    last_exp[a][b][s] = e;
                    sbq.push_back('{a, b, s, e});
                end
    endtask

    task automatic drain_sb(input string tag);
        sb_t it;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            chk($sformatf("%s[%0d][%0d][%0d]", tag, it.a, it.b, it.s), out[it.a][it.b][it.s], it.v);
        end
    endtask

    task automatic check_hold(input string tag);
        for (int a = 0; a < NUM_ACTIONS; a++)
            for (int b = 0; b < NUM_BELIEF; b++)
                for (int s = 0; s < NUM_STATES; s++)
                    chk($sformatf("%s[%0d][%0d][%0d]", tag, a, b, s), out[a][b][s], last_exp[a][b][s]);
    endtask

    task automatic check_zero(input string tag);
        for (int a = 0; a < NUM_ACTIONS; a++)
            for (int b = 0; b < NUM_BELIEF; b++)
                for (int s = 0; s < NUM_STATES; s++)
                    chk($sformatf("%s[%0d][%0d][%0d]", tag, a, b, s), out[a][b][s], 16'h0);
        chk({tag, "_en_step3"}, {15'h0, en_step3}, 16'h0);
    endtask

    task automatic randomize_inputs();
        foreach (alpha[a, o, k, s]) alpha[a][o][k][s] = word_t'($urandom);
        foreach (reward[a, b, s]) reward[a][b][s] = word_t'($urandom);
        foreach (belief[b, s]) belief[b][s] = belief_t'($urandom);
    endtask

    task automatic set_example();
        foreach (alpha[a, o, k, s]) alpha[a][o][k][s] = (s == 0) ? 16'sd1 : 16'sd0;
        for (int a = 0; a < NUM_ACTIONS; a++)
            for (int o = 0; o < NUM_OBS; o++)
                alpha[a][o][2 * a + o][0] = -16'sd1;
        for (int b = 0; b < NUM_BELIEF; b++) begin
            reward[0][b][0] = 16'sd1; reward[0][b][1] = 16'sd0;
            reward[1][b][0] = 16'sd0; reward[1][b][1] = 16'sd0;
            reward[2][b][0] = 16'sd0; reward[2][b][1] = 16'sd1;
            belief[b][0] = belief_t'(b * 16'h1000);
            belief[b][1] = belief_t'(16'hFFFF - b * 16'h1000);
        end
    endtask

    task automatic set_uniform(input logic [15:0] av, input logic [15:0] rv);
        foreach (alpha[a, o, k, s]) alpha[a][o][k][s] = word_t'(av);
        foreach (reward[a, b, s]) reward[a][b][s] = word_t'(rv);
        foreach (belief[b, s]) belief[b][s] = belief_t'($urandom);
    endtask

    task automatic pulse(input string tag);
        @(negedge clk);
        en = 1'b1;
        push_expected();
        @(posedge clk);
        #1;
        en = 1'b0;
        chk({tag, "_en_step3"}, {15'h0, en_step3}, 16'h1);
        drain_sb(tag);
    endtask

    ex_t  ex_tab [6];
    tie_t tie_tab [3];

    initial begin
        ex_tab[0] = '{0, 0, 16'h0001, 16'h0000};
        ex_tab[1] = '{0, 1, 16'h0003, 16'h0000};
        ex_tab[2] = '{1, 1, 16'h0002, 16'h0000};
        ex_tab[3] = '{2, 0, 16'h0002, 16'h0001};
        ex_tab[4] = '{2, 1, 16'h0002, 16'h0001};
        ex_tab[5] = '{1, 0, 16'h0002, 16'h0000};
        // k7 and k12 tie on dot (belief s1 = 0) but differ in s1, exposing which one won
        tie_tab[0] = '{16'd10, 16'd10, 16'd300, 16'd5, 16'd300, -16'd7, 16'h8000, 16'd600, 16'd10};
        tie_tab[1] = '{-16'd5, 16'd3, 16'd1000, -16'd100, 16'd1000, 16'd100, 16'hFFFF, 16'd2000, -16'd200};
        tie_tab[2] = '{16'd0, 16'd0, 16'd7, 16'd1, 16'd7, 16'd2, 16'h0001, 16'd14, 16'd2};

        // reset with random inputs, before any clock edge
        randomize_inputs();
        en = 1'b1;
        #2;
        check_zero("reset");
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // worked example
        set_example();
        pulse("example");
        foreach (ex_tab[i]) begin
            chk($sformatf("ex_a%0d_b%0d_s0", ex_tab[i].a, ex_tab[i].b), out[ex_tab[i].a][ex_tab[i].b][0], ex_tab[i].e0);
            chk($sformatf("ex_a%0d_b%0d_s1", ex_tab[i].a, ex_tab[i].b), out[ex_tab[i].a][ex_tab[i].b][1], ex_tab[i].e1);
        end

        // hold: inputs churn while en=0, outputs must not move
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            randomize_inputs();
            @(posedge clk);
            #1;
            chk($sformatf("hold_en_step3_c%0d", c), {15'h0, en_step3}, 16'h0);
            if (c == 0 || c == 5) check_hold($sformatf("hold_c%0d", c));
        end

        // tie-break with en held high across vectors
        foreach (tie_tab[i]) begin
            @(negedge clk);
            en = 1'b1;
            foreach (alpha[a, o, k, s]) alpha[a][o][k][s] = word_t'((s == 0) ? tie_tab[i].base0 : tie_tab[i].base1);
            foreach (alpha[a, o, k, s]) begin
                if (k == 7) alpha[a][o][k][s] = word_t'((s == 0) ? tie_tab[i].k7_0 : tie_tab[i].k7_1);
                if (k == 12) alpha[a][o][k][s] = word_t'((s == 0) ? tie_tab[i].k12_0 : tie_tab[i].k12_1);
            end
            foreach (reward[a, b, s]) reward[a][b][s] = '0;
            foreach (belief[b, s]) belief[b][s] = (s == 0) ? tie_tab[i].bel0 : 16'h0;
            push_expected();
            @(posedge clk);
            #1;
            chk($sformatf("tie%0d_en_step3", i), {15'h0, en_step3}, 16'h1);
            drain_sb($sformatf("tie%0d", i));
            chk($sformatf("tie%0d_a2_b9_s0", i), out[2][9][0], tie_tab[i].e0);
            chk($sformatf("tie%0d_a0_b3_s1", i), out[0][3][1], tie_tab[i].e1);
        end
        @(negedge clk);
        en = 1'b0;

        // overflow, positive and negative
        set_uniform(16'h7FFF, 16'h7FFF);
        pulse("ovf_pos");
`ifdef STEP2_SATURATE_EN
        chk("ovf_pos_const", out[1][4][1], 16'h7FFF);
`else
        chk("ovf_pos_const", out[1][4][1], 16'h7FFD);
`endif
        set_uniform(16'h8001, 16'h8000);
        pulse("ovf_neg");
`ifdef STEP2_SATURATE_EN
        chk("ovf_neg_const", out[0][15][0], 16'h8000);
`else
        chk("ovf_neg_const", out[0][15][0], 16'h8002);
`endif

        // reset between edges while en=1, then reload on the first edge after release
        @(negedge clk);
        set_example();
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        sbq.delete();
        #1;
        rst_n = 1'b1;
        push_expected();
        @(posedge clk);
        #1;
        en = 1'b0;
        chk("reload_en_step3", {15'h0, en_step3}, 16'h1);
        drain_sb("reload");
        chk("reload_a0_b1_s0", out[0][1][0], 16'h0003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
